// File: rtl/assoc_req_bridge_pkg.sv
// Shared types and constants for the sv_assoc request bridge.
package assoc_pkg;

  localparam int unsigned ASSOC_AW = 64;
  localparam int unsigned ASSOC_DW = 64;

  typedef struct packed {
    logic                write;
    logic [ASSOC_AW-1:0] addr;
    logic [ASSOC_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/assoc_req_bridge_if.sv
// Bus bundle for the bridge: traffic request/response handshakes plus the
// sv_assoc strobe/data side. The bridge takes the slave view.
interface assoc_req_bridge_if import assoc_pkg::*; #(
  parameter int unsigned AW        = ASSOC_AW,
  parameter int unsigned DW        = ASSOC_DW,
  parameter int unsigned RSP_DEPTH = 4
);

  localparam int unsigned OW = $clog2(RSP_DEPTH + 1);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          wen;
  logic          ren;
  logic [DW-1:0] wdin;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdout;
  logic [OW-1:0] outstanding;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdout,
    input  req_ready, rsp_valid, rsp_rdata, wen, ren, wdin, addr, outstanding
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdout,
    output req_ready, rsp_valid, rsp_rdata, wen, ren, wdin, addr, outstanding
  );

endinterface

// File: rtl/assoc_req_bridge_sfifo.sv
// Synchronous FIFO with extra-MSB pointers; accepts a push while full when a
// pop happens in the same cycle.
module assoc_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr[PW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/assoc_req_bridge.sv
// Request/response bridge in front of sv_assoc: queues traffic requests,
// issues single-cycle wen/ren strobes in order, and returns read data in
// order under a credit limit that keeps the response FIFO from overflowing.
module assoc_req_bridge import assoc_pkg::*; #(
  parameter int unsigned AW        = ASSOC_AW,
  parameter int unsigned DW        = ASSOC_DW,
  parameter int unsigned REQ_DEPTH = 8,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input logic                clk,
  input logic                rst,
  assoc_req_bridge_if.slave  bus
);

  localparam int unsigned     OW         = $clog2(RSP_DEPTH + 1);
  localparam logic [OW-1:0]   LP_CREDITS = OW'(RSP_DEPTH);

  req_t            w_req_in;
  req_t            w_req_head;
  logic            w_req_push;
  logic            w_req_pop;
  logic            w_req_full;
  logic            w_req_empty;
  logic            w_issue_wr;
  logic            w_issue_rd;
  logic            w_rsp_push;
  logic            w_rsp_pop;
  logic            w_rsp_full;
  logic            w_rsp_empty;
  logic [DW-1:0]   w_rsp_head;
  logic            r_wen;
  logic            r_ren;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdin;
  logic [RD_LAT-1:0] r_lat;
  logic [OW-1:0]   r_outstanding;

  // Pack the incoming request into the queue entry.
  always_comb begin
    w_req_in       = '0;
    w_req_in.write = bus.req_write;
    w_req_in.addr  = bus.req_addr;
    w_req_in.wdata = bus.req_wdata;
  end

  assign w_issue_wr = !w_req_empty && w_req_head.write;
  assign w_issue_rd = !w_req_empty && !w_req_head.write && (r_outstanding < LP_CREDITS);
  assign w_req_pop  = w_issue_wr || w_issue_rd;
  // Ready also covers the full-but-popping case so a full queue keeps streaming.
  assign bus.req_ready = !rst && (!w_req_full || w_req_pop);
  assign w_req_push    = bus.req_valid && bus.req_ready;

  assign w_rsp_push    = r_lat[RD_LAT-1];
  assign bus.rsp_valid = !rst && !w_rsp_empty;
  assign w_rsp_pop     = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = w_rsp_head;

  assign bus.wen         = r_wen;
  assign bus.ren         = r_ren;
  assign bus.addr        = r_addr;
  assign bus.wdin        = r_wdin;
  assign bus.outstanding = r_outstanding;

  assoc_sfifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_push),
    .i_pop   (w_req_pop),
    .i_din   (w_req_in),
    .o_full  (w_req_full),
    .o_empty (w_req_empty),
    .o_head  (w_req_head)
  );

  assoc_sfifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_pop   (w_rsp_pop),
    .i_din   (bus.rdout),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_head  (w_rsp_head)
  );

  // Registered sv_assoc strobes; addr/wdin hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_ren  <= 1'b0;
      r_addr <= '0;
      r_wdin <= '0;
    end else begin
      r_wen <= w_issue_wr;
      r_ren <= w_issue_rd;
      if (w_req_pop)  r_addr <= w_req_head.addr;
      if (w_issue_wr) r_wdin <= w_req_head.wdata;
    end
  end

  // Read-latency tag pipe; rdout is captured when the tag reaches the end.
  always_ff @(posedge clk) begin
    if (rst) r_lat <= '0;
    else     r_lat <= (r_lat << 1) | RD_LAT'(r_ren);
  end

  // Credit counter: reads issued but not yet consumed from the response FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue_rd, w_rsp_pop})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Protocol invariants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_wen && r_ren));
      assert (!(w_rsp_push && w_rsp_full && !w_rsp_pop));
      assert (r_outstanding <= LP_CREDITS);
    end
  end

endmodule
